// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_port_arbiter: shares one SRAM controller between IF (read-only) and |
// | MEM (read/write) with per-port ready, latched read data and IF           |
// | starvation guard. Optional macro SRAM_ARB_RR_EN selects round-robin.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int IF_STARVE_LIMIT = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_ctl_read_en,
  output logic              o_ctl_write_en,
  output logic [ADDR_W-1:0] o_ctl_address,
  output logic [DATA_W-1:0] o_ctl_write_data,
  input  logic [DATA_W-1:0] i_ctl_read_data,
  input  logic              i_ctl_ready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IF  = 2'd1,
    GRANT_MEM = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_started;
  logic              r_ctl_read_en;
  logic              r_ctl_write_en;
  logic [ADDR_W-1:0] r_ctl_address;
  logic [DATA_W-1:0] r_ctl_write_data;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;

  logic w_mem_req;
  logic w_complete;
  logic w_pick_if;

  assign w_mem_req  = i_mem_rd | i_mem_wr;
  assign w_complete = (r_state != IDLE) & r_started & i_ctl_ready;

`ifdef SRAM_ARB_RR_EN
  logic r_last_if;
  assign w_pick_if = i_if_req & (~w_mem_req | ~r_last_if);
`else
  localparam logic [3:0] c_starve_limit = 4'(IF_STARVE_LIMIT);
  logic [3:0] r_starve_cnt;
  assign w_pick_if = i_if_req & (~w_mem_req | (r_starve_cnt >= c_starve_limit));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_started        <= 1'b0;
      r_ctl_read_en    <= 1'b0;
      r_ctl_write_en   <= 1'b0;
      r_ctl_address    <= '0;
      r_ctl_write_data <= '0;
      r_if_rdata       <= '0;
      r_mem_rdata      <= '0;
`ifdef SRAM_ARB_RR_EN
      r_last_if        <= 1'b0;
`else
      r_starve_cnt     <= 4'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_started <= 1'b0;
          if (i_if_req | w_mem_req) begin
            if (w_pick_if) begin
              r_state        <= GRANT_IF;
              r_ctl_read_en  <= 1'b1;
              r_ctl_write_en <= 1'b0;
              r_ctl_address  <= i_if_addr;
`ifdef SRAM_ARB_RR_EN
              r_last_if      <= 1'b1;
`else
              r_starve_cnt   <= 4'd0;
`endif
            end else begin
              // A write wins over a simultaneous read request.
              r_state          <= GRANT_MEM;
              r_ctl_read_en    <= ~i_mem_wr;
              r_ctl_write_en   <= i_mem_wr;
              r_ctl_address    <= i_mem_addr;
              r_ctl_write_data <= i_mem_wdata;
`ifdef SRAM_ARB_RR_EN
              r_last_if        <= 1'b0;
`else
              if (i_if_req && (r_starve_cnt != 4'hF))
                r_starve_cnt <= r_starve_cnt + 4'd1;
`endif
            end
          end
        end
        GRANT_IF, GRANT_MEM: begin
          if (!i_ctl_ready) begin
            r_started <= 1'b1;
          end else if (r_started) begin
            r_state        <= IDLE;
            r_started      <= 1'b0;
            r_ctl_read_en  <= 1'b0;
            r_ctl_write_en <= 1'b0;
            if (r_ctl_read_en) begin
              if (r_state == GRANT_IF) r_if_rdata  <= i_ctl_read_data;
              else                     r_mem_rdata <= i_ctl_read_data;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_if_ready       = ~i_if_req  | ((r_state == GRANT_IF)  & w_complete);
  assign o_mem_ready      = ~w_mem_req | ((r_state == GRANT_MEM) & w_complete);
  assign o_if_rdata       = r_if_rdata;
  assign o_mem_rdata      = r_mem_rdata;
  assign o_ctl_read_en    = r_ctl_read_en;
  assign o_ctl_write_en   = r_ctl_write_en;
  assign o_ctl_address    = r_ctl_address;
  assign o_ctl_write_data = r_ctl_write_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_port_arbiter: randomized bench with SRAM controller model and a  |
// | transaction-level arbitration/data reference.                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sram_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ctl_read_en;
  logic        ctl_write_en;
  logic [31:0] ctl_address;
  logic [31:0] ctl_write_data;
  logic [31:0] ctl_read_data;
  logic        ctl_ready;

  int n_chk = 0;
  int n_err = 0;
  int lat_cfg = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.IF_STARVE_LIMIT(LIMIT), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ready(if_ready),
    .i_mem_rd(mem_rd), .i_mem_wr(mem_wr), .i_mem_addr(mem_addr), .i_mem_wdata(mem_wdata),
    .o_mem_rdata(mem_rdata), .o_mem_ready(mem_ready),
    .o_ctl_read_en(ctl_read_en), .o_ctl_write_en(ctl_write_en),
    .o_ctl_address(ctl_address), .o_ctl_write_data(ctl_write_data),
    .i_ctl_read_data(ctl_read_data), .i_ctl_ready(ctl_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hE3A01005;
    return (32'(i) * 32'h0001_0003) ^ 32'hA500_0000;
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [9:0] w;
    w = 10'($urandom);
    return {20'h0, w, 2'b00};
  endfunction

  // SRAM controller: drops ready after sampling an enable, stays busy for
  // the configured latency, then raises ready for one completion cycle.
  logic [31:0] sram [1024];
  bit          c_busy, c_done, c_wr;
  int          c_cnt;
  logic [9:0]  c_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_busy <= 1'b0; c_done <= 1'b0; c_wr <= 1'b0; c_cnt <= 0; c_idx <= '0;
      ctl_ready <= 1'b1; ctl_read_data <= '0;
      for (int i = 0; i < 1024; i++) sram[i] <= init_word(i);
    end else if (c_done) begin
      c_done <= 1'b0;
    end else if (c_busy) begin
      if (c_cnt <= 1) begin
        c_busy <= 1'b0; c_done <= 1'b1; ctl_ready <= 1'b1;
        if (!c_wr) ctl_read_data <= sram[c_idx];
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end else if (ctl_read_en || ctl_write_en) begin
      c_busy <= 1'b1; ctl_ready <= 1'b0;
      c_cnt  <= (lat_cfg != 0) ? lat_cfg : int'($urandom_range(4, 1));
      c_idx  <= ctl_address[11:2];
      c_wr   <= ctl_write_en;
      if (ctl_write_en) sram[ctl_address[11:2]] <= ctl_write_data;
    end
  end

  // Transaction-level reference: who should win each arbitration, what the
  // controller must see, and what each port's read data must become.
  int          m_port, m_losses;
  bit          m_last_if, m_pick_if, m_en, m_comp, m_wr;
  bit          m_prev_en, m_pif, m_pmem, m_pmwr;
  logic [31:0] m_addr, m_wdata, m_piaddr, m_pmaddr, m_pmwdata, m_if_rd, m_mem_rd;
  logic [31:0] ref_mem [1024];
  int          grant_log [$];

  always @(negedge clk) begin
    if (rst) begin
      m_prev_en = 0; m_pif = 0; m_pmem = 0; m_pmwr = 0; m_port = 0; m_wr = 0;
      m_losses = 0; m_last_if = 0; m_if_rd = '0; m_mem_rd = '0; m_addr = '0; m_wdata = '0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    end else begin
      m_en = ctl_read_en | ctl_write_en;
      check("if_rdata", if_rdata, m_if_rd);
      check("mem_rdata", mem_rdata, m_mem_rd);
      if (m_en && !m_prev_en) begin
        if (m_pif && m_pmem)
`ifdef SRAM_ARB_RR_EN
          m_pick_if = !m_last_if;
`else
          m_pick_if = (m_losses >= LIMIT);
`endif
        else
          m_pick_if = m_pif;
        if (m_pick_if) begin
          m_port = 1; m_losses = 0; m_addr = m_piaddr; m_wr = 0;
        end else begin
          m_port = 2; m_addr = m_pmaddr; m_wr = m_pmwr; m_wdata = m_pmwdata;
          if (m_pif) m_losses = (m_losses < 15) ? m_losses + 1 : 15;
        end
        m_last_if = m_pick_if;
        grant_log.push_back(m_port);
        check("grant_addr", ctl_address, m_addr);
        check("grant_wr", b2w(ctl_write_en), b2w(m_wr));
        check("grant_rd", b2w(ctl_read_en), b2w(!m_wr));
        if (m_wr) check("grant_wdata", ctl_write_data, m_wdata);
      end else if (m_en) begin
        check("hold_addr", ctl_address, m_addr);
        check("hold_wr", b2w(ctl_write_en), b2w(m_wr));
      end
      m_comp = m_en && c_done;
      check("if_ready", b2w(if_ready), b2w(!if_req || (m_comp && m_port == 1)));
      check("mem_ready", b2w(mem_ready), b2w(!(mem_rd || mem_wr) || (m_comp && m_port == 2)));
      if (m_comp) begin
        if (m_wr)             ref_mem[m_addr[11:2]] = m_wdata;
        else if (m_port == 1) m_if_rd  = ref_mem[m_addr[11:2]];
        else                  m_mem_rd = ref_mem[m_addr[11:2]];
      end
      m_prev_en = m_en; m_pif = if_req; m_pmem = mem_rd | mem_wr; m_pmwr = mem_wr;
      m_piaddr = if_addr; m_pmaddr = mem_addr; m_pmwdata = mem_wdata;
    end
  end

  task automatic wait_done(input bit is_if);
    int  k;
    bit  hit;
    k = 0; hit = 0;
    while (k < 100 && !hit) begin
      @(negedge clk);
      hit = is_if ? (if_req && if_ready) : ((mem_rd || mem_wr) && mem_ready);
      k++;
    end
    check(is_if ? "if_done_timeout" : "mem_done_timeout", b2w(hit), 32'd1);
    @(posedge clk); #1;
    if (is_if) if_req = 0;
    else begin mem_rd = 0; mem_wr = 0; end
  endtask

  task automatic traffic(input int n_cyc, input int pct, input int wr_pct);
    bit d_if, d_mem;
    int cyc;
    cyc = 0;
    while (cyc < n_cyc || if_req || mem_rd || mem_wr) begin
      @(negedge clk);
      d_if  = if_req && if_ready;
      d_mem = (mem_rd || mem_wr) && mem_ready;
      @(posedge clk); #1;
      if (d_if) if_req = 0;
      if (d_mem) begin mem_rd = 0; mem_wr = 0; end
      if (cyc < n_cyc) begin
        if (!if_req && $urandom_range(99) < pct) begin
          if_req = 1; if_addr = rnd_addr();
        end
        if (!(mem_rd || mem_wr) && $urandom_range(99) < pct) begin
          mem_addr = rnd_addr(); mem_wdata = $urandom;
          if ($urandom_range(99) < wr_pct) begin
            mem_wr = 1; mem_rd = ($urandom_range(9) == 0);
          end else begin
            mem_rd = 1;
          end
        end
      end
      cyc++;
      if (cyc > n_cyc + 400) begin
        check("traffic_timeout", 32'd1, 32'd0);
        if_req = 0; mem_rd = 0; mem_wr = 0;
        break;
      end
    end
  endtask

  initial begin
    int base, k;
    int pat [10];
    logic [31:0] prev_rd;
`ifdef SRAM_ARB_RR_EN
    pat = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
`else
    pat = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", b2w(ctl_read_en), 32'd0);
    check("rst_wr_en", b2w(ctl_write_en), 32'd0);
    check("rst_addr", ctl_address, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_if_ready", b2w(if_ready), 32'd1);
    rst = 0;

    // IF-only read of 0x40, 3-cycle controller.
    lat_cfg = 3;
    @(posedge clk); #1; if_req = 1; if_addr = 32'h40;
    @(negedge clk); check("if_en_c0", b2w(ctl_read_en), 32'd0);
    @(negedge clk); check("if_en_c1", b2w(ctl_read_en), 32'd1);
    check("if_stall", b2w(if_ready), 32'd0);
    check("if_mem_ready", b2w(mem_ready), 32'd1);
    wait_done(1);
    @(negedge clk); check("if_rdata_e3", if_rdata, 32'hE3A01005);

    // MEM write.
    @(posedge clk); #1; mem_wr = 1; mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF;
    @(negedge clk); @(negedge clk);
    check("wr_en", b2w(ctl_write_en), 32'd1);
    check("wr_data", ctl_write_data, 32'hDEADBEEF);
    check("wr_stall", b2w(mem_ready), 32'd0);
    wait_done(0);
    @(negedge clk);
    check("wr_sram", sram[256], 32'hDEADBEEF);
    check("wr_rdata_hold", mem_rdata, 32'd0);

    // Requester changes mid-grant.
    lat_cfg = 4;
    @(posedge clk); #1; mem_rd = 1; mem_addr = 32'h10;
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1; mem_addr = 32'h20;
    @(negedge clk); check("mid_addr", ctl_address, 32'h10);
    wait_done(0);
    @(negedge clk); check("mid_rdata", mem_rdata, init_word(4));
    prev_rd = init_word(4);

    // Illegal read+write: write wins, read data untouched.
    lat_cfg = 2;
    @(posedge clk); #1; mem_rd = 1; mem_wr = 1; mem_addr = 32'h8; mem_wdata = 32'h5;
    wait_done(0);
    @(negedge clk);
    check("ill_sram", sram[2], 32'h5);
    check("ill_rdata", mem_rdata, prev_rd);

    // Contention with both requesters permanently busy.
    base = grant_log.size();
    traffic(60, 100, 0);
    check("cont_count", b2w(grant_log.size() >= base + 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      k = (base + i < grant_log.size()) ? grant_log[base + i] : 0;
      check("cont_grant", 32'(k), 32'(pat[i]));
    end

    // Randomized mixed traffic with random latency.
    lat_cfg = 0;
    traffic(600, 40, 40);
    traffic(200, 90, 50);

    // Asynchronous reset during an IF access.
    lat_cfg = 4;
    @(posedge clk); #1; if_req = 1; if_addr = 32'h80;
    k = 0;
    do begin @(negedge clk); k++; end while (!(ctl_read_en && !ctl_ready) && k < 50);
    check("arst_busy", b2w(ctl_read_en && !ctl_ready), 32'd1);
    #2 rst = 1;
    #1;
    check("arst_rd_en", b2w(ctl_read_en), 32'd0);
    check("arst_addr", ctl_address, 32'd0);
    check("arst_if_rdata", if_rdata, 32'd0);
    check("arst_mem_rdata", mem_rdata, 32'd0);
    if_req = 0;
    @(posedge clk); @(negedge clk); @(posedge clk); #1; rst = 0;

    // Recovery after reset.
    lat_cfg = 1;
    @(posedge clk); #1; if_req = 1; if_addr = 32'h40;
    wait_done(1);
    @(negedge clk); check("post_rst_rdata", if_rdata, 32'hE3A01005);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single SRAM controller between two pipeline requesters: instruction fetch (IF, read-only) and the memory stage (MEM, read/write).
- Sits between both stages and the SRAM controller. Drives the controller's read_en/write_en/address/write_data and consumes its ready.
- Gives each requester a per-port ready (freeze = ~ready), latched read data and fixed-priority arbitration with an IF starvation guard.

Parameters:
IF_STARVE_LIMIT, 4, consecutive IF losses after which IF wins the next arbitration (1..15)
ADDR_W, 32, address width
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
if_req  in  1  IF read request, held until if_ready
if_addr  in  ADDR_W  IF address
if_rdata  out  DATA_W  IF read data, registered
if_ready  out  1  IF not stalled
mem_rd  in  1  MEM read request, held until mem_ready
mem_wr  in  1  MEM write request, held until mem_ready
mem_addr  in  ADDR_W  MEM address
mem_wdata  in  DATA_W  MEM write data
mem_rdata  out  DATA_W  MEM read data, registered
mem_ready  out  1  MEM not stalled
ctl_read_en  out  1  controller read enable, registered
ctl_write_en  out  1  controller write enable, registered
ctl_address  out  ADDR_W  controller address, registered
ctl_write_data  out  DATA_W  controller write data, registered
ctl_read_data  in  DATA_W  controller read data, valid when ctl_ready rises
ctl_ready  in  1  controller ready: low while an access is in progress

Behaviour:
- Reset (async, rst=1):
  - State=IDLE; all ctl_* outputs=0; if_rdata=mem_rdata=0; starve_cnt=0; started=0.
  - Takes effect immediately, including mid-access.
- Downstream contract:
  - The controller drops ctl_ready at the edge after it first samples an enable high.
  - ctl_ready returns high for the completion cycle.
- Completion rule:
  - In a GRANT state, started is set when ctl_ready=0 is sampled.
  - Completion = GRANT state & started & ctl_ready=1.
- FSM states: IDLE, GRANT_IF, GRANT_MEM.
- IDLE arbitration:
  - MEM request only (mem_rd|mem_wr) -> GRANT_MEM.
  - IF only -> GRANT_IF.
  - Both pending: MEM wins unless starve_cnt >= IF_STARVE_LIMIT, in which case IF wins.
  - Neither -> stay in IDLE.
- On the grant edge, latch the winner's address and write data and the op into the ctl_* registers. Enables go high one cycle after the request is seen in IDLE.
- Op decode:
  - MEM with mem_wr=1 -> write, even if mem_rd=1 (illegal combination, write takes precedence; mem_rdata is not updated).
  - Otherwise read.
  - IF is always a read.
- GRANT_x: enables held from the latched values. Requester changes during the grant are ignored.
- On the completion edge:
  - Clear enables and started; return to IDLE.
  - Capture ctl_read_data into the granted port's rdata (reads only).
  - Re-arbitration happens in IDLE, giving a minimum one-cycle bubble between accesses.
- starve_cnt:
  - Increments, saturating at 15, when IF is pending in IDLE and MEM is granted.
  - Cleared when IF is granted.
- Ready outputs (combinational):
  - if_ready = ~if_req | (state==GRANT_IF & completion). mem_ready is the same function of the MEM request and GRANT_MEM.
  - A requester with no request is never stalled.
- rdata registers hold their value until the next read completion on the same port.

Optional Feature:
SRAM_ARB_RR_EN:
- Defined: round-robin arbitration. A last_grant flag (reset=MEM, so IF wins the first tie) selects the port not granted last when both request. starve_cnt and IF_STARVE_LIMIT are unused.
- Undefined: fixed MEM priority with starvation guard, as above.

Test Plan:
- IF-only read: if_req=1, if_addr=0x40; controller busy 3 cycles returns 0xE3A01005 -> ctl_read_en high from cycle 1; if_ready=1 only on the completion cycle; if_rdata=0xE3A01005 after it; mem_ready stays 1.
- MEM write: mem_wr=1, mem_addr=0x400, mem_wdata=0xDEADBEEF -> ctl_write_en=1, ctl_address=0x400, ctl_write_data=0xDEADBEEF held until completion; mem_rdata unchanged; mem_ready low until completion.
- Contention: if_req and mem_rd held high with fresh requests every time; expected behaviour depends on the build:
  - Fixed priority: MEM wins 4 consecutive grants, the 5th goes to IF, then starve_cnt=0.
  - SRAM_ARB_RR_EN: grants strictly alternate IF, MEM, IF...
- Requester change mid-grant: mem_addr switched from 0x10 to 0x20 during GRANT_MEM -> ctl_address stays 0x10 until completion.
- Async reset mid-access: rst pulsed during GRANT_IF with ctl_ready=0 -> ctl_read_en=0 immediately without a clock edge; state IDLE; if_rdata=0.
- Illegal mem_rd=mem_wr=1 with addr 0x8, wdata 0x5 -> write issued, mem_rdata holds its previous value.
